// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared state type, sizing helpers and saturation limits for matvec_gen
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam int M_DEF = 3;
  localparam int N_DEF = 3;
  localparam int W_ADDR_W_DEF = $clog2(M_DEF * N_DEF);
  localparam int X_ADDR_W_DEF = $clog2(N_DEF);
  localparam int R_ADDR_W_DEF = $clog2(M_DEF);

  // A depth of 1 still needs a one-bit address so every counter has a real register.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [63:0] sat_max(input int aw);
    return (64'd1 << (aw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int aw);
    return ~sat_max(aw);
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// rtl/matvec_mac.sv - registered signed multiply-accumulate with clear/enable
// MATVEC_SAT_EN selects clamping on accumulator overflow; otherwise the sum wraps.
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int DW = 14,
  parameter int AW = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   base;
  logic signed [AW-1:0]   acc_next;

  assign prod     = a * b;
  assign prod_ext = AW'(prod);
  assign base     = clr ? '0 : acc;

`ifdef MATVEC_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = AW'(sat_max(AW));
  localparam logic signed [AW-1:0] ACC_MIN = AW'(sat_min(AW));

  logic signed [AW:0] sum;

  assign sum = {base[AW-1], base} + {prod_ext[AW-1], prod_ext};

  // The two top bits of the widened sum disagree exactly when the AW-bit result overflowed.
  always_comb begin
    acc_next = sum[AW-1:0];
    if (sum[AW] != sum[AW-1]) acc_next = sum[AW] ? ACC_MIN : ACC_MAX;
  end
`else
  assign acc_next = base + prod_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (en) acc <= acc_next;
  end

endmodule

// File: rtl/matvec_mem.sv
// rtl/matvec_mem.sv - simple dual-port storage, one write port, registered read (1-cycle latency)
module matvec_mem #(
  parameter int DEPTH = 9,
  parameter int DW    = 14,
  parameter int ABW   = 4
) (
  input  logic           clk,
  input  logic           we,
  input  logic [ABW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [ABW-1:0] raddr,
  output logic [DW-1:0]  rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/matvec_gen.sv
// rtl/matvec_gen.sv - streaming signed matrix-vector multiplier y = W*x with W reuse
// MATVEC_SAT_EN (in matvec_mac) selects saturating accumulation.
module matvec_gen
  import matvec_pkg::*;
#(
  parameter int M  = 3,
  parameter int N  = 3,
  parameter int DW = 14,
  parameter int AW = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic signed [DW-1:0] input_data,
  input  logic                 input_reuse,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic signed [AW-1:0] output_data,
  output logic                 output_last
);

  localparam int WA = addr_w(M * N);
  localparam int XA = addr_w(N);
  localparam int RA = addr_w(M);
  localparam int SW = addr_w(N + 2);

  localparam logic [WA-1:0] W_LAST   = WA'(M * N - 1);
  localparam logic [XA-1:0] X_LAST   = XA'(N - 1);
  localparam logic [RA-1:0] R_LAST   = RA'(M - 1);
  localparam logic [SW-1:0] S_RD_END = SW'(N);
  localparam logic [SW-1:0] S_DONE   = SW'(N + 1);
  localparam logic [SW-1:0] S_FIRST  = SW'(1);

  state_t          state;
  logic [WA-1:0]   widx;
  logic [XA-1:0]   col;
  logic [RA-1:0]   row;
  logic [SW-1:0]   step;
  logic            w_loaded;
  logic            loading_x;
  logic            first;

  logic                 in_fire;
  logic                 out_fire;
  logic                 take_x;
  logic                 w_we;
  logic                 x_we;
  logic                 rd_phase;
  logic                 mac_en;
  logic                 mac_clr;
  logic signed [DW-1:0] w_rdata;
  logic signed [DW-1:0] x_rdata;
  logic signed [AW-1:0] acc;

  assign in_fire  = input_valid && input_ready;
  assign out_fire = output_valid && output_ready;
  // Reuse is only honoured on the first element of a problem and only when W is valid.
  assign take_x   = loading_x || (first && input_reuse && w_loaded);
  assign w_we     = in_fire && !take_x;
  assign x_we     = in_fire && take_x;

  // Steps 0..N-1 issue reads, steps 1..N accumulate the data returned one cycle later.
  assign rd_phase = (state == COMPUTE) && (step < S_RD_END);
  assign mac_en   = (state == COMPUTE) && (step != '0) && (step <= S_RD_END);
  assign mac_clr  = (step == S_FIRST);

  matvec_mem #(.DEPTH(M * N), .DW(DW), .ABW(WA)) u_w_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (widx),
    .wdata (input_data),
    .raddr (widx),
    .rdata (w_rdata)
  );

  matvec_mem #(.DEPTH(N), .DW(DW), .ABW(XA)) u_x_mem (
    .clk   (clk),
    .we    (x_we),
    .waddr (col),
    .wdata (input_data),
    .raddr (col),
    .rdata (x_rdata)
  );

  matvec_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk (clk),
    .rst (reset),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (w_rdata),
    .b   (x_rdata),
    .acc (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      widx         <= '0;
      col          <= '0;
      row          <= '0;
      step         <= '0;
      w_loaded     <= 1'b0;
      loading_x    <= 1'b0;
      first        <= 1'b0;
      input_ready  <= 1'b0;
      output_valid <= 1'b0;
      output_data  <= '0;
      output_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= LOAD;
          input_ready <= 1'b1;
          widx        <= '0;
          col         <= '0;
          row         <= '0;
          step        <= '0;
          first       <= 1'b1;
          loading_x   <= 1'b0;
        end
        LOAD: begin
          if (in_fire) begin
            first <= 1'b0;
            if (!take_x) begin
              if (widx == W_LAST) begin
                widx      <= '0;
                w_loaded  <= 1'b1;
                loading_x <= 1'b1;
              end else begin
                widx <= widx + 1'b1;
              end
            end else begin
              loading_x <= 1'b1;
              if (col == X_LAST) begin
                col         <= '0;
                step        <= '0;
                input_ready <= 1'b0;
                state       <= COMPUTE;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        COMPUTE: begin
          // widx runs straight through all rows, so row r starts at r*N without a multiplier.
          if (rd_phase) begin
            if (widx != W_LAST) widx <= widx + 1'b1;
            if (col != X_LAST) col <= col + 1'b1;
          end
          if (step == S_DONE) begin
            state        <= OUTPUT;
            output_valid <= 1'b1;
            output_data  <= acc;
            output_last  <= (row == R_LAST);
          end else begin
            step <= step + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            output_valid <= 1'b0;
            output_last  <= 1'b0;
            if (row == R_LAST) begin
              state <= IDLE;
            end else begin
              row   <= row + 1'b1;
              col   <= '0;
              step  <= '0;
              state <= COMPUTE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_gen.sv
// tb/tb_matvec_gen.sv - directed checks of matvec_gen at 3x3, 2x4 and 4x2 sizes
module tb_matvec_gen;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_reuse;
  logic out_ready;
  logic signed [13:0] in_data;
  logic [1:0] sel;

  logic iv_a, iv_b, iv_c, or_a, or_b, or_c;
  logic rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, ol_a, ol_b, ol_c;
  logic signed [27:0] od_a, od_b, od_c;

  logic cur_ready, cur_valid, cur_last;
  logic signed [27:0] cur_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ref_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iv_a = in_valid && (sel == 2'd0);
  assign iv_b = in_valid && (sel == 2'd1);
  assign iv_c = in_valid && (sel == 2'd2);
  assign or_a = out_ready && (sel == 2'd0);
  assign or_b = out_ready && (sel == 2'd1);
  assign or_c = out_ready && (sel == 2'd2);

  assign cur_ready = (sel == 2'd0) ? rdy_a : (sel == 2'd1) ? rdy_b : rdy_c;
  assign cur_valid = (sel == 2'd0) ? ov_a  : (sel == 2'd1) ? ov_b  : ov_c;
  assign cur_last  = (sel == 2'd0) ? ol_a  : (sel == 2'd1) ? ol_b  : ol_c;
  assign cur_data  = (sel == 2'd0) ? od_a  : (sel == 2'd1) ? od_b  : od_c;

  matvec_gen #(.M(3), .N(3), .DW(14), .AW(28)) u_dut_a (
    .clk(clk), .reset(reset), .input_valid(iv_a), .input_ready(rdy_a), .input_data(in_data),
    .input_reuse(in_reuse), .output_valid(ov_a), .output_ready(or_a), .output_data(od_a),
    .output_last(ol_a)
  );

  matvec_gen #(.M(2), .N(4), .DW(14), .AW(28)) u_dut_b (
    .clk(clk), .reset(reset), .input_valid(iv_b), .input_ready(rdy_b), .input_data(in_data),
    .input_reuse(in_reuse), .output_valid(ov_b), .output_ready(or_b), .output_data(od_b),
    .output_last(ol_b)
  );

  matvec_gen #(.M(4), .N(2), .DW(14), .AW(28)) u_dut_c (
    .clk(clk), .reset(reset), .input_valid(iv_c), .input_ready(rdy_c), .input_data(in_data),
    .input_reuse(in_reuse), .output_valid(ov_c), .output_ready(or_c), .output_data(od_c),
    .output_last(ol_c)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int d, input bit reuse, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 14'(d);
    in_reuse = reuse;
    while (!cur_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cur_ready) check("send_timeout", 0, 1);
    @(negedge clk);
    ref_cyc  = cyc;
    in_valid = 1'b0;
    in_reuse = 1'b0;
  endtask

  // Expects out_ready=1; lat<0 skips the latency check.
  task automatic recv(input string tag, input longint exp, input bit last, input int lat);
    int t = 0;
    while (!cur_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, cur_valid, 1);
    if (lat >= 0) check({tag, "_lat"}, cyc - ref_cyc, lat);
    check({tag, "_data"}, cur_data, exp);
    check({tag, "_last"}, cur_last, last);
    @(negedge clk);
    ref_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    longint ovf;
    int t;
`ifdef MATVEC_SAT_EN
    ovf = 134217727;
`else
    ovf = -67108864;
`endif
    sel = 2'd0; in_valid = 1'b0; in_reuse = 1'b0; in_data = '0; out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", cur_ready, 0);
    check("rst_valid", cur_valid, 0);
    check("rst_data", cur_data, 0);
    check("rst_last", cur_last, 0);
    reset = 1'b0;
    #1 check("idle_ready", cur_ready, 0);
    @(negedge clk);
    check("load_ready", cur_ready, 1);

    // 3x3 basic: W=1..9, x=1,2,3
    for (int i = 1; i <= 9; i++) send(i, 1'b0, 1'b0);
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0);
    recv("t1_y0", 14, 0, 5);
    recv("t1_y1", 32, 0, 5);
    recv("t1_y2", 50, 1, 5);

    // Backpressure on first result; stray input_valid must be ignored
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(i, 1'b0, 1'b0);
    send(-1, 0, 0); send(0, 0, 0); send(2, 0, 0);
    t = 0;
    while (!cur_valid && t < 50) begin @(negedge clk); t++; end
    check("bp_lat", cyc - ref_cyc, 5);
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", cur_valid, 1);
      check("bp_data", cur_data, 5);
      check("bp_last", cur_last, 0);
      check("bp_in_ready", cur_ready, 0);
      if (k == 3) begin in_valid = 1'b1; in_data = 14'sd77; end
      if (k == 5) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    ref_cyc = cyc;
    recv("bp_y1", 8, 0, 5);
    recv("bp_y2", 11, 1, 5);

    // Overflow: all elements -8192, each product 2^26
    for (int i = 0; i < 12; i++) send(-8192, 1'b0, 1'b0);
    recv("ovf_y0", ovf, 0, 5);
    recv("ovf_y1", ovf, 0, 5);
    recv("ovf_y2", ovf, 1, 5);

    // Reset mid-COMPUTE, then reuse request must still load a full W
    for (int i = 0; i < 9; i++) send(2, 1'b0, 1'b0);
    send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", cur_ready, 0);
    check("mid_rst_valid", cur_valid, 0);
    check("mid_rst_data", cur_data, 0);
    check("mid_rst_last", cur_last, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(1, 1'b1, 1'b0); send(2, 1'b1, 1'b0); send(3, 1'b1, 1'b0);
    check("rst_reuse_still_loading", cur_ready, 1);
    for (int i = 4; i <= 9; i++) send(i, 1'b1, 1'b0);
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0);
    recv("rst_y0", 14, 0, 5);
    recv("rst_y1", 32, 0, 5);
    recv("rst_y2", 50, 1, 5);

    // 2x4 with W reuse on the second problem
    sel = 2'd1;
    @(negedge clk);
    send(1, 0, 0); send(-1, 0, 0); send(2, 0, 0); send(-2, 0, 0);
    send(3, 0, 0); send(3, 0, 0);  send(3, 0, 0); send(3, 0, 0);
    send(5, 0, 0); send(6, 0, 0);  send(7, 0, 0); send(8, 0, 0);
    recv("b_y0", -3, 0, 6);
    recv("b_y1", 78, 1, 6);
    send(1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(1, 1'b0, 1'b0);
    check("b_reuse_4_inputs", cur_ready, 0);
    recv("b_r_y0", 0, 0, 6);
    recv("b_r_y1", 12, 1, 6);

    // 4x2 with random input gaps
    sel = 2'd2;
    @(negedge clk);
    send(1, 0, 1);  send(2, 0, 1);
    send(3, 0, 1);  send(-4, 0, 1);
    send(-5, 0, 1); send(6, 0, 1);
    send(7, 0, 1);  send(8, 0, 1);
    send(10, 0, 1); send(-3, 0, 1);
    recv("c_y0", 4, 0, 4);
    recv("c_y1", 42, 0, 4);
    recv("c_y2", -68, 0, 4);
    recv("c_y3", 46, 1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
